// File: rtl/mmio_bus_master.sv
// CPU-side master for the shared MMIO bus: turns one-cycle load/store requests into WR/RD strobe sequences plus a one-cycle ack.
// Optional out-of-window error response is enabled by defining MMIO_ERR_EN.
module mmio_bus_master #(
  parameter int                    DATA_WIDTH = 64,
  parameter int                    ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE    = 'h2000,
  parameter logic [ADDR_WIDTH-1:0] IO_SIZE    = 'h100,
  parameter int                    READ_WAIT  = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_busy,
  output logic                  cpu_ack,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_err,
  inout  wire  [DATA_WIDTH-1:0] bus_data,
  output logic [ADDR_WIDTH-1:0] bus_address,
  output logic                  bus_read,
  output logic                  bus_write,
  output logic [1:0]            o_dbg_state,
  output logic                  o_dbg_in_window
);

  // Handshake: cpu_req is only looked at while cpu_busy=0 (IDLE); every accepted
  // request ends with exactly one cpu_ack cycle unless reset drops it first.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [3:0] RD_WAIT_INIT = 4'(READ_WAIT);

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_we;
  logic                  r_err;
  logic [3:0]            r_cnt;

  logic [ADDR_WIDTH:0]   w_win_top;
  logic                  w_in_window;
  logic                  w_addr_err;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_resp;

  // Window top is one bit wider so IO_BASE+IO_SIZE cannot wrap.
  assign w_win_top   = {1'b0, IO_BASE} + {1'b0, IO_SIZE};
  assign w_in_window = (cpu_addr >= IO_BASE) && ({1'b0, cpu_addr} < w_win_top);

`ifdef MMIO_ERR_EN
  assign w_addr_err = ~w_in_window;
`else
  assign w_addr_err = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (cpu_req) begin
          if (w_addr_err)  w_next = S_RESP;
          else if (cpu_we) w_next = S_WR;
          else             w_next = S_RD;
        end
      end
      S_WR:    w_next = S_RESP;
      S_RD:    if (r_cnt == 4'd0) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cpu_req) begin
            r_addr  <= cpu_addr;
            r_wdata <= cpu_wdata;
            r_we    <= cpu_we;
            r_err   <= w_addr_err;
            r_rdata <= '0;
            r_cnt   <= RD_WAIT_INIT;
          end
        end
        S_RD: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd0) r_rdata <= bus_data;
        end
        default: ;
      endcase
    end
  end

  assign w_wr   = (r_state == S_WR);
  assign w_rd   = (r_state == S_RD);
  assign w_resp = (r_state == S_RESP);

  // Bus side is decoded straight from state, so strobes can never overlap.
  assign bus_write   = w_wr;
  assign bus_read    = w_rd;
  assign bus_address = (w_wr | w_rd) ? r_addr : '0;
  assign bus_data    = w_wr ? r_wdata : 'z;

  assign cpu_busy  = (r_state != S_IDLE);
  assign cpu_ack   = w_resp;
  assign cpu_err   = w_resp & r_err;
  assign cpu_rdata = (w_resp & ~r_we & ~r_err) ? r_rdata : '0;

  assign o_dbg_state     = r_state;
  assign o_dbg_in_window = w_in_window;

endmodule

// File: tb/tb_mmio_bus_master.sv
// Bench for mmio_bus_master: directed steps then random traffic, checked against a transaction-level model.
// A bus keeper drives zero whenever no strobe is up, so any stray master drive shows as a data conflict.
module tb_mmio_bus_master;

  localparam int RW = 1;
`ifdef MMIO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clock     = 1'b0;
  logic        reset     = 1'b1;
  logic        cpu_req   = 1'b0;
  logic        cpu_we    = 1'b0;
  logic [63:0] cpu_addr  = '0;
  logic [63:0] cpu_wdata = '0;
  logic        cpu_busy;
  logic        cpu_ack;
  logic [63:0] cpu_rdata;
  logic        cpu_err;
  wire  [63:0] bus_data;
  logic [63:0] bus_address;
  logic        bus_read;
  logic        bus_write;
  logic [1:0]  dbg_state;
  logic        dbg_in_window;

  mmio_bus_master #(
    .DATA_WIDTH(64), .ADDR_WIDTH(64), .IO_BASE(64'h2000), .IO_SIZE(64'h100), .READ_WAIT(RW)
  ) dut (
    .clock(clock), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_busy(cpu_busy), .cpu_ack(cpu_ack),
    .cpu_rdata(cpu_rdata), .cpu_err(cpu_err), .bus_data(bus_data), .bus_address(bus_address),
    .bus_read(bus_read), .bus_write(bus_write), .o_dbg_state(dbg_state),
    .o_dbg_in_window(dbg_in_window)
  );

  always #5 clock = ~clock;

  int          n_cmp    = 0;
  int          n_mism   = 0;
  int          n_ack    = 0;
  int          n_rd_cyc = 0;
  logic [63:0] last_rdata = '0;

  // Peripheral: memory plus an address-derived default pattern.
  logic [63:0] periph_mem [logic [63:0]];
  logic [63:0] ref_mem    [logic [63:0]];
  logic        periph_en = 1'b1;
  logic [63:0] periph_q  = '0;

  function automatic logic [63:0] dflt_word(input logic [63:0] a);
    return {a[31:0] ^ 32'hC0DEF00D, ~a[31:0]};
  endfunction

  function automatic logic [63:0] periph_word(input logic [63:0] a);
    return periph_mem.exists(a) ? periph_mem[a] : dflt_word(a);
  endfunction

  function automatic bit in_window(input logic [63:0] a);
    return (a >= 64'h2000) && (a < 64'h2100);
  endfunction

  assign bus_data = periph_en ? periph_q : 'z;

  always @(bus_read or bus_write or bus_address) begin
    periph_en = !bus_write;
    periph_q  = bus_read ? periph_word(bus_address) : 64'h0;
  end

  always @(negedge clock) begin
    if (bus_write) periph_mem[bus_address] = bus_data;
  end

  // Transaction model: phase counts cycles since the accepting edge.
  bit          m_active = 1'b0;
  int          m_phase  = 0;
  int          m_last   = 0;
  bit          m_we     = 1'b0;
  bit          m_err    = 1'b0;
  logic [63:0] m_addr   = '0;
  logic [63:0] m_data   = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mism++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_advance();
    if (reset) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      if (cpu_req) begin
        m_active = 1'b1;
        m_phase  = 1;
        m_we     = cpu_we;
        m_addr   = cpu_addr;
        m_err    = ERR_EN && !in_window(cpu_addr);
        if (m_err) begin
          m_last = 1;
          m_data = '0;
        end else if (cpu_we) begin
          m_last = 2;
          m_data = cpu_wdata;
          ref_mem[cpu_addr] = cpu_wdata;
        end else begin
          m_last = RW + 2;
          m_data = ref_mem.exists(cpu_addr) ? ref_mem[cpu_addr] : dflt_word(cpu_addr);
        end
      end
    end else begin
      m_phase++;
      if (m_phase > m_last) m_active = 1'b0;
    end
  endtask

  task automatic check_outputs();
    bit e_wr;
    bit e_rd;
    bit e_ack;
    e_wr  = m_active && !m_err && m_we && (m_phase == 1);
    e_rd  = m_active && !m_err && !m_we && (m_phase >= 1) && (m_phase <= RW + 1);
    e_ack = m_active && (m_phase == m_last);
    chk("cpu_busy", cpu_busy, m_active);
    chk("bus_write", bus_write, e_wr);
    chk("bus_read", bus_read, e_rd);
    chk("bus_address", bus_address, (e_wr || e_rd) ? m_addr : 64'h0);
    chk("bus_data", bus_data, (e_wr || e_rd) ? m_data : 64'h0);
    chk("cpu_ack", cpu_ack, e_ack);
    chk("cpu_err", cpu_err, e_ack && m_err);
    chk("cpu_rdata", cpu_rdata, (e_ack && !m_we && !m_err) ? m_data : 64'h0);
    chk("in_window", dbg_in_window, in_window(cpu_addr));
  endtask

  task automatic tick();
    model_advance();
    @(posedge clock);
    #1;
    check_outputs();
    if (cpu_ack) begin
      n_ack++;
      last_rdata = cpu_rdata;
    end
    if (bus_read) n_rd_cyc++;
  endtask

  task automatic drive(input bit req, input bit we, input logic [63:0] a, input logic [63:0] d);
    cpu_req   = req;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = d;
  endtask

  initial begin
    // Reset held for two cycles
    reset = 1'b1;
    tick();
    tick();
    chk("rst_busy", cpu_busy, 1'b0);
    chk("rst_bus_data", bus_data, 64'h0);
    reset = 1'b0;

    // Store in window
    drive(1'b1, 1'b1, 64'h2000, 64'h1234);
    tick();
    chk("st_write", bus_write, 1'b1);
    chk("st_addr", bus_address, 64'h2000);
    chk("st_data", bus_data, 64'h1234);
    cpu_req = 1'b0;
    tick();
    chk("st_ack", cpu_ack, 1'b1);
    chk("st_err", cpu_err, 1'b0);
    tick();
    chk("st_release", bus_data, 64'h0);

    // Seed the peripheral, then load it back
    drive(1'b1, 1'b1, 64'h2000, 64'hDEADBEEF);
    tick();
    cpu_req = 1'b0;
    tick();
    tick();
    n_rd_cyc = 0;
    n_ack    = 0;
    drive(1'b1, 1'b0, 64'h2000, {$urandom, $urandom});
    tick();
    cpu_req = 1'b0;
    repeat (RW + 3) tick();
    chk("ld_read_cycles", n_rd_cyc, RW + 1);
    chk("ld_ack_count", n_ack, 1);
    chk("ld_rdata", last_rdata, 64'hDEADBEEF);

    // Store below the window
    n_ack = 0;
    drive(1'b1, 1'b1, 64'h1000, 64'h55AA);
    tick();
    cpu_req = 1'b0;
    chk("oow_write", bus_write, !ERR_EN);
    chk("oow_ack", cpu_ack, ERR_EN);
    chk("oow_err", cpu_err, ERR_EN);
    repeat (3) tick();
    chk("oow_ack_count", n_ack, 1);

    // Request held high for six cycles
    n_ack = 0;
    drive(1'b1, 1'b1, 64'h2008, {$urandom, $urandom});
    repeat (6) tick();
    cpu_req = 1'b0;
    repeat (3) tick();
    chk("held_ack_count", n_ack, 2);

    // Reset during the first read cycle drops the load
    n_ack = 0;
    drive(1'b1, 1'b0, 64'h2040, 64'h0);
    tick();
    chk("rst_rd_first", bus_read, 1'b1);
    reset   = 1'b1;
    cpu_req = 1'b0;
    tick();
    chk("rst_rd_read", bus_read, 1'b0);
    chk("rst_rd_busy", cpu_busy, 1'b0);
    reset = 1'b0;
    repeat (5) tick();
    chk("rst_rd_no_ack", n_ack, 0);

    // Random traffic including window edges and occasional reset
    repeat (600) begin
      logic [63:0] a;
      case ($urandom_range(0, 5))
        0:       a = 64'h2000 + 64'($urandom_range(0, 31) * 8);
        1:       a = 64'h1FFF;
        2:       a = 64'h20FF;
        3:       a = 64'h2100;
        4:       a = {$urandom, $urandom};
        default: a = 64'hFFFF_FFFF_FFFF_FFF8;
      endcase
      reset = ($urandom_range(0, 99) == 0);
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, {$urandom, $urandom});
      tick();
    end
    reset   = 1'b0;
    cpu_req = 1'b0;
    repeat (RW + 4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mism);
    $finish;
  end

endmodule

// File: doc/mmio_bus_master.md
Name: mmio_bus_master

Overview:
- CPU-side master for the shared memory-mapped I/O bus. It drives the bus that the seven-segment display and other peripherals decode.
- Converts single-cycle CPU load/store requests into bus strobe sequences: address, read/write, and the bidirectional 64-bit data bus.
- Returns a one-cycle acknowledge with read data.
- Sits between the datapath's memory stage and all bus peripherals.

Parameters:
- DATA_WIDTH, 64, width of CPU data and bus_data.
- ADDR_WIDTH, 64, width of CPU and bus addresses.
- IO_BASE, 64'h2000, lowest valid I/O address (inclusive).
- IO_SIZE, 64'h100, size of the valid I/O window; valid when IO_BASE <= addr < IO_BASE+IO_SIZE.
- READ_WAIT, 1, extra cycles bus_read is held before data is sampled (0..15).

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  request strobe, sampled only in IDLE.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_WIDTH  request address.
- cpu_wdata  in  DATA_WIDTH  store data.
- cpu_busy  out  1  high in every state except IDLE.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_WIDTH  load data, valid while cpu_ack=1.
- cpu_err  out  1  error flag, valid while cpu_ack=1.
- bus_data  inout  DATA_WIDTH  shared data bus; driven only in WR, high-Z otherwise.
- bus_address  out  ADDR_WIDTH  bus address.
- bus_read  out  1  read strobe to peripherals.
- bus_write  out  1  write strobe to peripherals.

Behaviour:
- Clock is clock; reset is synchronous and active-high.
- Reset values: state=IDLE; cpu_busy, cpu_ack, cpu_err, bus_read, bus_write = 0; cpu_rdata=0; bus_address=0; bus_data=high-Z; latched addr/data/we = 0.
- States: IDLE, WR, RD, RESP.
- IDLE:
  - On cpu_req=1, latch cpu_addr, cpu_we and cpu_wdata.
  - If the address is out of window (MMIO_ERR_EN defined), go to RESP with err pending.
  - Else if we=1, go to WR.
  - Else go to RD with wait counter = READ_WAIT.
- WR (exactly 1 cycle):
  - bus_write=1, bus_address=latched addr, bus_data driven with latched wdata.
  - Next state RESP.
- RD:
  - bus_read=1, bus_address=latched addr, bus_data high-Z.
  - Counter decrements each cycle.
  - On the edge ending the cycle where counter==0, capture bus_data into the rdata register and go to RESP.
  - bus_read is therefore high for READ_WAIT+1 cycles.
- RESP (exactly 1 cycle):
  - cpu_ack=1.
  - cpu_rdata = captured data for loads; 0 for stores and errors.
  - cpu_err = pending err.
  - Next state IDLE.
- Outside WR/RD: bus_address=0 and bus_read=bus_write=0. bus_read and bus_write are never high in the same cycle. The master never drives bus_data while bus_read=1.
- Latency, with the request sampled at edge k:
  - Store: WR during cycle k, ack during cycle k+1.
  - Load: ack READ_WAIT+2 cycles after the request cycle.
- cpu_busy: 0 in IDLE, 1 otherwise. cpu_req while busy is ignored, not queued. A req held high is re-accepted on the first IDLE cycle after RESP.
- Window check uses unsigned compare; IO_BASE+IO_SIZE is computed at ADDR_WIDTH+1 bits so the top of the window cannot wrap.
- Read data captured from undriven bus lines is passed through unmodified.
- Reset mid-transaction: the next edge forces IDLE and all strobes low; the transaction is dropped with no cpu_ack. A reset coinciding with cpu_req wins.

Optional Feature:
- Macro MMIO_ERR_EN.
- Defined: out-of-window requests go IDLE→RESP with no bus strobes; cpu_ack=1 and cpu_err=1 one cycle after the request cycle; cpu_rdata=0.
- Undefined: no window check. Every request is issued on the bus, and cpu_err is tied to 0.

Test Plan:
- Reset held 2 cycles → all outputs 0, bus_data high-Z, cpu_busy=0.
- Store addr 64'h2000, wdata 64'h1234 → next cycle bus_write=1, bus_address=64'h2000, bus_data=64'h1234; following cycle cpu_ack=1, cpu_err=0, then bus_data high-Z.
- Load 64'h2000, READ_WAIT=1, peripheral model drives 64'hDEADBEEF → bus_read high 2 cycles; cpu_ack with cpu_rdata=64'hDEADBEEF; no cycle where the master drives bus_data while bus_read=1.
- Store addr 64'h1000:
  - with MMIO_ERR_EN → no bus_write; cpu_ack=1 and cpu_err=1 next cycle.
  - without MMIO_ERR_EN → bus_write=1 with bus_address=64'h1000; cpu_err=0.
- cpu_req held high for 6 cycles with store addr 64'h2008 → exactly two transactions, each separated by an IDLE cycle; requests during busy ignored.
- Reset asserted in the 1st RD cycle → next cycle bus_read=0, state IDLE; no cpu_ack is ever produced for that load.
